// File: rtl/combo_lock_ctrl.sv
// combo_lock_ctrl: combination-lock controller. Takes one decimal digit per
// enter strobe, compares a NUM_DIGITS-digit code, counts consecutive failures
// into a timed lockout, and can optionally reprogram the code in the field.
// Optional feature macro: COMBO_LOCK_PROG_EN (PROG state and writable code).
// Ports:
//   clk, rst_n            clock, asynchronous active-low reset
//   digit_in[9:0], enter  switch value and its one-cycle consume strobe
//   prog                  program request, sampled with enter while OPEN
//   state_o[2:0]          0 ENTRY, 1 OPEN, 2 CLOSED, 3 LOCKOUT, 4 PROG
//   digit_o, digit_err    combinational display digit / out-of-range flag
//   unlocked              high in OPEN (and PROG)
//   idx_o, fail_cnt_o     current digit position, consecutive failed codes
module combo_lock_ctrl #(
  parameter int                      NUM_DIGITS     = 6,
  parameter logic [NUM_DIGITS*4-1:0] DEFAULT_CODE   = 24'h419236,
  parameter int                      MAX_FAILS      = 3,
  parameter int                      LOCKOUT_CYCLES = 16
) (
  input  logic                          clk,
  input  logic                          rst_n,
  input  logic [9:0]                    digit_in,
  input  logic                          enter,
  input  logic                          prog,
  output logic [2:0]                    state_o,
  output logic [3:0]                    digit_o,
  output logic                          digit_err,
  output logic                          unlocked,
  output logic [$clog2(NUM_DIGITS)-1:0] idx_o,
  output logic [3:0]                    fail_cnt_o
);

  localparam int IW = $clog2(NUM_DIGITS);
  localparam int CW = NUM_DIGITS * 4;
  localparam int TW = $clog2(LOCKOUT_CYCLES + 1);
  localparam logic [IW-1:0] LAST_IDX = IW'(NUM_DIGITS - 1);
  localparam logic [3:0]    FAIL_LIM = 4'(MAX_FAILS);
  localparam logic [TW-1:0] TMR_LOAD = TW'(LOCKOUT_CYCLES - 1);

  typedef enum logic [2:0] {
    ST_ENTRY   = 3'd0,
    ST_OPEN    = 3'd1,
    ST_CLOSED  = 3'd2,
    ST_LOCKOUT = 3'd3,
    ST_PROG    = 3'd4
  } state_t;

  state_t          state;
  logic [IW-1:0]   idx;
  logic            mismatch;
  logic [3:0]      fail_cnt;
  logic [TW-1:0]   lock_tmr;
  logic [CW-1:0]   code;

  logic            in_range;
  logic [3:0]      code_digit;
  logic            digit_bad;
  logic [3:0]      fail_next;

`ifdef COMBO_LOCK_PROG_EN
  logic [CW-1:0]   shadow;
  logic [CW-1:0]   shadow_nxt;

  // Shadow image with the current digit merged in; used both for the
  // per-digit write and for the atomic commit on the last digit.
  always_comb begin
    shadow_nxt = shadow;
    shadow_nxt[{idx, 2'b00} +: 4] = digit_in[3:0];
  end
`else
  // Without reprogramming the code is fixed and prog has no function.
  logic unused_prog;
  assign code        = DEFAULT_CODE;
  assign unused_prog = prog;
`endif

  assign in_range   = (digit_in <= 10'd9);
  assign code_digit = code[{idx, 2'b00} +: 4];
  assign digit_bad  = !in_range || (digit_in[3:0] != code_digit);
  assign fail_next  = fail_cnt + 4'd1;

  // Display path is purely combinational so the encoder tracks the switches.
  assign digit_o   = in_range ? digit_in[3:0] : 4'd0;
  assign digit_err = !in_range && ((state == ST_ENTRY) || (state == ST_PROG));

  assign state_o    = state;
  assign idx_o      = idx;
  assign fail_cnt_o = fail_cnt;
`ifdef COMBO_LOCK_PROG_EN
  assign unlocked   = (state == ST_OPEN) || (state == ST_PROG);
`else
  assign unlocked   = (state == ST_OPEN);
`endif

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state    <= ST_ENTRY;
      idx      <= '0;
      mismatch <= 1'b0;
      fail_cnt <= 4'd0;
      lock_tmr <= '0;
`ifdef COMBO_LOCK_PROG_EN
      code     <= DEFAULT_CODE;
      shadow   <= DEFAULT_CODE;
`endif
    end else begin
      case (state)
        ST_ENTRY: begin
          if (enter) begin
            if (idx == LAST_IDX) begin
              // Verdict uses the sticky flag plus the final digit itself.
              idx      <= '0;
              mismatch <= 1'b0;
              if (!mismatch && !digit_bad) begin
                state    <= ST_OPEN;
                fail_cnt <= 4'd0;
              end else if (fail_next == FAIL_LIM) begin
                state    <= ST_LOCKOUT;
                lock_tmr <= TMR_LOAD;
                fail_cnt <= 4'd0;
              end else begin
                state    <= ST_CLOSED;
                fail_cnt <= fail_next;
              end
            end else begin
              // A wrong digit never aborts entry, so timing leaks nothing.
              idx      <= idx + IW'(1);
              mismatch <= mismatch | digit_bad;
            end
          end
        end

        ST_OPEN: begin
          if (enter) begin
`ifdef COMBO_LOCK_PROG_EN
            state <= prog ? ST_PROG : ST_ENTRY;
`else
            state <= ST_ENTRY;
`endif
          end
        end

        ST_CLOSED: begin
          if (enter) state <= ST_ENTRY;
        end

        ST_LOCKOUT: begin
          // Loaded with LOCKOUT_CYCLES-1 so the state lasts exactly
          // LOCKOUT_CYCLES clocks including the terminal zero cycle.
          if (lock_tmr == '0) state <= ST_ENTRY;
          else                lock_tmr <= lock_tmr - TW'(1);
        end

`ifdef COMBO_LOCK_PROG_EN
        ST_PROG: begin
          if (enter && in_range) begin
            shadow <= shadow_nxt;
            if (idx == LAST_IDX) begin
              code  <= shadow_nxt;
              idx   <= '0;
              state <= ST_ENTRY;
            end else begin
              idx <= idx + IW'(1);
            end
          end
        end
`endif

        default: begin
          state <= ST_ENTRY;
          idx   <= '0;
        end
      endcase
    end
  end

endmodule

// File: doc/combo_lock_ctrl.md
# combo_lock_ctrl

Parametrised combination-lock controller, the next generation of the board-level six-digit lock. It accepts one decimal digit per `enter` strobe from the 10-bit switch bank and compares a full code of `NUM_DIGITS` digits. It adds a failed-attempt lockout and optional in-field code reprogramming. It sits between the switch/key debouncing and the 7-segment display encoder, which renders `state_o`/`digit_o`.

## Interface
Parameters:
- `NUM_DIGITS`, 6: code length, 2..16.
- `DEFAULT_CODE`, 24'h419236: reset code, `NUM_DIGITS*4` bits; digit 0 (entered first) is in bits [3:0]. The default entry order is 6,3,2,9,1,4.
- `MAX_FAILS`, 3: number of consecutive wrong codes that triggers lockout, 1..15.
- `LOCKOUT_CYCLES`, 16: lockout duration in clocks, at least 1.

Ports:
- `clk` in 1: rising-edge clock, the only clock.
- `rst_n` in 1: reset, asynchronous, active-low.
- `digit_in` in 10: switch value; a value above 9 is out of range.
- `enter` in 1: one-cycle strobe that consumes `digit_in`.
- `prog` in 1: program request, sampled with `enter` in OPEN.
- `state_o` out 3: 0 ENTRY, 1 OPEN, 2 CLOSED, 3 LOCKOUT, 4 PROG.
- `digit_o` out 4: `digit_in[3:0]` when `digit_in` ≤ 9, else 0.
- `digit_err` out 1: high when `digit_in` > 9 in ENTRY or PROG. Combinational.
- `unlocked` out 1: high in OPEN and PROG.
- `idx_o` out `$clog2(NUM_DIGITS)`: the digit position being entered.
- `fail_cnt_o` out 4: count of consecutive failed codes.

## Operation
- Registers:
  - `code`, `NUM_DIGITS*4` bits; reset value `DEFAULT_CODE`.
  - `idx`.
  - `mismatch`: sticky flag.
  - `fail_cnt`.
  - `lock_tmr`.
  - `state`.
- ENTRY, on `enter`:
  - A digit counts as a mismatch if it is > 9 or differs from `code[idx]`; `mismatch` is set accordingly.
  - A mismatch does not abort entry. All `NUM_DIGITS` digits are always consumed.
- Final digit (`idx == NUM_DIGITS-1`) with `enter`:
  - All digits match → OPEN, `fail_cnt` ← 0.
  - Otherwise `fail_cnt`+1. If the new count equals `MAX_FAILS` → LOCKOUT, `lock_tmr` ← `LOCKOUT_CYCLES-1`, `fail_cnt` ← 0. Else → CLOSED.
  - In every case `idx` ← 0 and `mismatch` ← 0.
- OPEN or CLOSED with `enter` → ENTRY. The digit presented with that `enter` is discarded.
- OPEN with `enter` and `prog` → PROG (only when the feature is compiled in).
- LOCKOUT:
  - `enter` is ignored.
  - `lock_tmr` decrements every cycle. At 0 the block moves to ENTRY.
- PROG:
  - An in-range digit with `enter` is written to `shadow[idx]`, and `idx` increments.
  - An out-of-range digit with `enter` is ignored; `idx` holds.
  - After the last digit, `code` ← `shadow` atomically and the block moves to ENTRY.
- Reset mid-operation:
  - `state` = ENTRY, `idx` = 0, `mismatch` = 0, `fail_cnt` = 0, `code` = `DEFAULT_CODE`.
  - Outputs after reset: `state_o` = 0, `unlocked` = 0, `idx_o` = 0, `fail_cnt_o` = 0.

## Timing
- `enter` is sampled on the rising edge of `clk`. `state_o`, `idx_o`, `fail_cnt_o` and `unlocked` update one cycle after the strobe.
- `digit_o` and `digit_err` are combinational from `digit_in` and `state`, with zero latency.
- Result latency: OPEN, CLOSED or LOCKOUT is visible one cycle after the final `enter`.
- Lockout lasts exactly `LOCKOUT_CYCLES` cycles in the LOCKOUT state; ENTRY is visible on the following cycle.
- Back-to-back `enter` strobes on consecutive cycles are legal. Each strobe consumes exactly one digit.
- `prog` is ignored outside OPEN.
- A new code takes effect for the first ENTRY digit after the commit.

## Configuration
- `COMBO_LOCK_PROG_EN` defined:
  - PROG state, `shadow` register and the `prog` input are active.
  - `code` is a writable register.
- `COMBO_LOCK_PROG_EN` undefined:
  - PROG is unreachable and `prog` is ignored.
  - `code` is the constant `DEFAULT_CODE`.
  - `unlocked` is high only in OPEN.

## Test plan
- Reset, then enter 6,3,2,9,1,4 → `state_o` = 1 and `unlocked` = 1 one cycle after the 6th `enter`; `fail_cnt_o` = 0.
- Display check: set `digit_in` = 12 in ENTRY → `digit_err` = 1 and `digit_o` = 0. Set `digit_in` = 9 → `digit_err` = 0 and `digit_o` = 9.
- For each position p in 0..5, enter 8 at p and the correct digits elsewhere → `state_o` = 2 only after the 6th `enter`; `fail_cnt_o` increments.
- Three consecutive wrong codes → `state_o` = 3 for exactly 16 cycles with `enter` ignored, then `state_o` = 0 and `fail_cnt_o` = 0.
- With `COMBO_LOCK_PROG_EN` defined:
  - Open the lock, then `enter` with `prog` = 1 and program 1,1,2,2,3,3 with an interleaved 12 (ignored) → `state_o` = 0.
  - Entering 1,1,2,2,3,3 then opens; entering 6,3,2,9,1,4 gives CLOSED.
- Assert `rst_n` = 0 mid-entry at `idx_o` = 3 → all outputs return to their reset values immediately, without waiting for a clock edge.
